i2s_rx_deserializer: RTL

Synthesizable I2S receiver (RX_SLAVE role) for the I2S AVIP DUT side. It recovers bit clock, word select and serial data sent by an external transmitter master, and deserializes left/right channel words of a configurable width. Each completed frame is presented on a valid/ready output port. It is the receive-end counterpart to the transmitter agent's drive path, and it uses the I2sGlobalPkg sizing and state encoding.

---
 rtl/i2s_rx_deserializer.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/i2s_rx_deserializer.sv
// rtl/i2s_rx_deserializer.sv - I2S slave receiver: sclk/ws/sd recovery, left/right word deserialization, valid/ready frame output
module i2s_rx_deserializer #(
  parameter int DATA_WIDTH   = 8,
  parameter int MAXIMUM_SIZE = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 en,
  input  logic [5:0]                           num_of_bits,
  input  logic                                 stereo,
  input  logic                                 sclk,
  input  logic                                 ws,
  input  logic                                 sd,
  output logic [DATA_WIDTH*MAXIMUM_SIZE-1:0]   left_data,
  output logic [DATA_WIDTH*MAXIMUM_SIZE-1:0]   right_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic                                 overflow,
  output logic [2:0]                           rx_state
);

  localparam int W = DATA_WIDTH * MAXIMUM_SIZE;

  typedef enum logic [2:0] {
    IDLE          = 3'd2,
    LEFT_CHANNEL  = 3'd3,
    RIGHT_CHANNEL = 3'd4
  } state_t;

  state_t         state, state_nx;
  logic           sclk_m, sclk_s, sclk_d, ws_m, ws_s, sd_m, sd_s;
  logic           sclk_rise, boundary, take;
  logic           ws_prev;
  logic [W-1:0]   shift, shift_nx, sh_in, word, left_hold, hold_nx;
  logic [5:0]     bit_cnt, cnt_nx, cnt_in, nbits_l, nbits_nx, nbits_in;
  logic           stereo_l, stereo_nx;
  logic           frame_done;
  logic [W-1:0]   frame_left, frame_right;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      {sclk_m, sclk_s, sclk_d} <= '0;
      {ws_m, ws_s, sd_m, sd_s} <= '0;
    end else begin
      sclk_m <= sclk;
      sclk_s <= sclk_m;
      sclk_d <= sclk_s;
      ws_m   <= ws;
      ws_s   <= ws_m;
      sd_m   <= sd;
      sd_s   <= sd_m;
    end
  end

  assign sclk_rise = sclk_s & ~sclk_d;
  assign boundary  = ws_s ^ ws_prev;
  assign rx_state  = state;
  assign nbits_in  = (num_of_bits == 6'd0 || {1'b0, num_of_bits} > 7'(W)) ? 6'(W) : num_of_bits;

  // The boundary-edge bit still belongs to the outgoing word; short words are padded with zero LSBs.
  assign take   = bit_cnt < nbits_l;
  assign sh_in  = take ? {shift[W-2:0], sd_s} : shift;
  assign cnt_in = take ? bit_cnt + 6'd1 : bit_cnt;
  assign word   = sh_in << (nbits_l - cnt_in);

  always_comb begin
    state_nx    = state;
    shift_nx    = shift;
    cnt_nx      = bit_cnt;
    hold_nx     = left_hold;
    nbits_nx    = nbits_l;
    stereo_nx   = stereo_l;
    frame_done  = 1'b0;
    frame_left  = word;
    frame_right = '0;
    if (!en) begin
      state_nx = IDLE;
      shift_nx = '0;
      cnt_nx   = '0;
    end else if (sclk_rise) begin
      case (state)
        IDLE: begin
          if (ws_prev && !ws_s) begin
            state_nx  = LEFT_CHANNEL;
            nbits_nx  = nbits_in;
            stereo_nx = stereo;
            shift_nx  = '0;
            cnt_nx    = '0;
          end
        end
        LEFT_CHANNEL: begin
          if (boundary) begin
            hold_nx    = word;
            frame_done = !stereo_l;
            state_nx   = RIGHT_CHANNEL;
            shift_nx   = '0;
            cnt_nx     = '0;
          end else begin
            shift_nx = sh_in;
            cnt_nx   = cnt_in;
          end
        end
        RIGHT_CHANNEL: begin
          if (boundary) begin
            frame_done  = stereo_l;
            frame_left  = left_hold;
            frame_right = word;
            state_nx    = LEFT_CHANNEL;
            nbits_nx    = nbits_in;
            stereo_nx   = stereo;
            shift_nx    = '0;
            cnt_nx      = '0;
          end else begin
            shift_nx = sh_in;
            cnt_nx   = cnt_in;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift     <= '0;
      bit_cnt   <= '0;
      left_hold <= '0;
      nbits_l   <= '0;
      stereo_l  <= 1'b0;
      ws_prev   <= 1'b0;
    end else begin
      shift     <= shift_nx;
      bit_cnt   <= cnt_nx;
      left_hold <= hold_nx;
      nbits_l   <= nbits_nx;
      stereo_l  <= stereo_nx;
      if (sclk_rise) ws_prev <= ws_s;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      left_data  <= '0;
      right_data <= '0;
      out_valid  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      overflow <= 1'b0;
      if (frame_done) begin
        if (!out_valid || out_ready) begin
          left_data  <= frame_left;
          right_data <= frame_right;
          out_valid  <= 1'b1;
        end else begin
          overflow <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
